// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC and arbitrates exception, redirect,
// halt and stall requests into the next fetch address and the flush pulses.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_4_reg, pc_4_next;
  logic        fetch_valid_reg, fetch_valid_next;
  logic        flush_reg, flush_next;
  logic        misalign_reg, misalign_next;
  logic        halted_reg, halted_next;
  logic [31:0] redir_target;
  logic [31:0] new_pc;

  // Jump wins over a simultaneous taken branch.
  assign redir_target = jump ? jump_target : br_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_VECTOR;
      pc_4_reg        <= RESET_VECTOR + 32'd4;
      fetch_valid_reg <= 1'b0;
      flush_reg       <= 1'b0;
      misalign_reg    <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pc_4_reg        <= pc_4_next;
      fetch_valid_reg <= fetch_valid_next;
      flush_reg       <= flush_next;
      misalign_reg    <= misalign_next;
      halted_reg      <= halted_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pc_4_next        = pc_4_reg;
    fetch_valid_next = 1'b0;
    flush_next       = 1'b0;
    misalign_next    = misalign_reg;
    halted_next      = 1'b0;
    new_pc           = pc_reg;
    case (state_reg)
      BOOT: begin
        state_next       = RUN;
        fetch_valid_next = 1'b1;
      end
      RUN: begin
        if (exc_req) begin
          new_pc           = EXC_VECTOR;
          pc_next          = new_pc;
          pc_4_next        = new_pc + 32'd4;
          fetch_valid_next = 1'b1;
          flush_next       = 1'b1;
        end else if (br_taken || jump) begin
          // A redirect beats a stall: the older instruction in EX takes precedence.
          if (redir_target[1:0] != 2'b00) begin
            new_pc        = EXC_VECTOR;
            misalign_next = 1'b1;
          end else begin
            new_pc = redir_target;
          end
          pc_next          = new_pc;
          pc_4_next        = new_pc + 32'd4;
          fetch_valid_next = 1'b1;
          flush_next       = 1'b1;
        end else if (halt_req) begin
          state_next  = HALT;
          halted_next = 1'b1;
        end else if (!stall) begin
          pc_next          = pc_4_reg;
          pc_4_next        = pc_4_reg + 32'd4;
          fetch_valid_next = 1'b1;
        end
      end
      HALT: begin
        if (exc_req) begin
          new_pc           = EXC_VECTOR;
          pc_next          = new_pc;
          pc_4_next        = new_pc + 32'd4;
          fetch_valid_next = 1'b1;
          flush_next       = 1'b1;
          state_next       = RUN;
        end else if (resume) begin
          fetch_valid_next = 1'b1;
          state_next       = RUN;
        end else begin
          halted_next = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign pc          = pc_reg;
  assign pc_4        = pc_4_reg;
  assign fetch_valid = fetch_valid_reg;
  assign flush_ifid  = flush_reg;
  assign flush_idex  = flush_reg;
  assign misalign    = misalign_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, redirects, misalign,
// exceptions, halt/resume, wrap-around and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        exc_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pc_4;
  logic        fetch_valid, flush_ifid, flush_idex, misalign, halted;

  int compared = 0;
  int mismatched = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req), .halt_req(halt_req),
    .resume(resume), .pc(pc), .pc_4(pc_4), .fetch_valid(fetch_valid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .misalign(misalign), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++; if (pc !== 32'h0 || pc_4 !== 32'h4) begin mismatched++; $display("FAIL reset_pc: pc=%h pc_4=%h expected 0/4", pc, pc_4); end
    compared++; if ({fetch_valid, flush_ifid, flush_idex, misalign, halted} !== 5'b0) begin mismatched++; $display("FAIL reset_flags: got %b expected 00000", {fetch_valid, flush_ifid, flush_idex, misalign, halted}); end
    rst_n = 1'b1;
    #1;
    compared++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin mismatched++; $display("FAIL boot: fv=%b pc=%h expected 0/0", fetch_valid, pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++; if (pc !== 32'(i * 4) || fetch_valid !== 1'b1) begin mismatched++; $display("FAIL seq_fetch%0d: pc=%h fv=%b expected %h/1", i, pc, fetch_valid, 32'(i * 4)); end
    end
    $display("reset/boot: pc=%h fv=%b", pc, fetch_valid);
  endtask

  task automatic test_stall();
    tick();
    compared++; if (pc !== 32'h10) begin mismatched++; $display("FAIL stall_pre: pc=%h expected 10", pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++; if (pc !== 32'h10 || pc_4 !== 32'h14 || fetch_valid !== 1'b0 || flush_ifid !== 1'b0) begin mismatched++; $display("FAIL stall_hold%0d: pc=%h pc_4=%h fv=%b fl=%b expected 10/14/0/0", i, pc, pc_4, fetch_valid, flush_ifid); end
    end
    stall = 1'b0;
    tick();
    compared++; if (pc !== 32'h14 || fetch_valid !== 1'b1) begin mismatched++; $display("FAIL stall_release: pc=%h fv=%b expected 14/1", pc, fetch_valid); end
    $display("stall: pc=%h", pc);
  endtask

  task automatic test_redirect();
    repeat (3) tick();
    compared++; if (pc !== 32'h20) begin mismatched++; $display("FAIL redir_pre: pc=%h expected 20", pc); end
    br_taken = 1'b1; br_target = 32'h100; stall = 1'b1;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    compared++; if (pc !== 32'h100 || pc_4 !== 32'h104 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin mismatched++; $display("FAIL branch_over_stall: pc=%h pc_4=%h fl=%b%b expected 100/104/11", pc, pc_4, flush_ifid, flush_idex); end
    tick();
    compared++; if (pc !== 32'h104 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin mismatched++; $display("FAIL branch_after: pc=%h fl=%b%b expected 104/00", pc, flush_ifid, flush_idex); end
    jump = 1'b1; jump_target = 32'h200; br_taken = 1'b1; br_target = 32'h100;
    tick();
    br_taken = 1'b0; jump_target = 32'h300;
    compared++; if (pc !== 32'h200 || flush_ifid !== 1'b1) begin mismatched++; $display("FAIL jump_over_branch: pc=%h fl=%b expected 200/1", pc, flush_ifid); end
    tick();
    jump = 1'b0;
    compared++; if (pc !== 32'h300 || flush_idex !== 1'b1) begin mismatched++; $display("FAIL back_to_back: pc=%h fl=%b expected 300/1", pc, flush_idex); end
    tick();
    compared++; if (pc !== 32'h304 || flush_ifid !== 1'b0) begin mismatched++; $display("FAIL redir_settle: pc=%h fl=%b expected 304/0", pc, flush_ifid); end
    $display("redirect: pc=%h", pc);
  endtask

  task automatic test_misalign();
    jump = 1'b1; jump_target = 32'h202;
    tick();
    jump = 1'b0;
    compared++; if (pc !== 32'h180 || misalign !== 1'b1 || flush_ifid !== 1'b1) begin mismatched++; $display("FAIL misalign_redir: pc=%h mis=%b fl=%b expected 180/1/1", pc, misalign, flush_ifid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++; if (pc !== 32'(32'h184 + i * 4) || misalign !== 1'b1) begin mismatched++; $display("FAIL misalign_sticky%0d: pc=%h mis=%b expected %h/1", i, pc, misalign, 32'(32'h184 + i * 4)); end
    end
    $display("misalign: pc=%h mis=%b", pc, misalign);
  endtask

  task automatic test_exception();
    exc_req = 1'b1; br_taken = 1'b1; br_target = 32'h100;
    tick();
    exc_req = 1'b0; br_taken = 1'b0;
    compared++; if (pc !== 32'h180 || pc_4 !== 32'h184 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin mismatched++; $display("FAIL exc_over_branch: pc=%h pc_4=%h fl=%b%b expected 180/184/11", pc, pc_4, flush_ifid, flush_idex); end
    tick();
    compared++; if (pc !== 32'h184 || flush_ifid !== 1'b0) begin mismatched++; $display("FAIL exc_after: pc=%h fl=%b expected 184/0", pc, flush_ifid); end
    $display("exception: pc=%h", pc);
  endtask

  task automatic test_halt();
    jump = 1'b1; jump_target = 32'h40;
    tick();
    jump = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    compared++; if (halted !== 1'b1 || pc !== 32'h40 || fetch_valid !== 1'b0) begin mismatched++; $display("FAIL halt_enter: h=%b pc=%h fv=%b expected 1/40/0", halted, pc, fetch_valid); end
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    compared++; if (halted !== 1'b1 || pc !== 32'h40 || flush_ifid !== 1'b0) begin mismatched++; $display("FAIL halt_ignore: h=%b pc=%h fl=%b expected 1/40/0", halted, pc, flush_ifid); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    compared++; if (halted !== 1'b0 || pc !== 32'h40 || fetch_valid !== 1'b1) begin mismatched++; $display("FAIL resume: h=%b pc=%h fv=%b expected 0/40/1", halted, pc, fetch_valid); end
    tick();
    compared++; if (pc !== 32'h44) begin mismatched++; $display("FAIL resume_next: pc=%h expected 44", pc); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    compared++; if (halted !== 1'b0 || pc !== 32'h180 || flush_idex !== 1'b1 || fetch_valid !== 1'b1) begin mismatched++; $display("FAIL halt_exc: h=%b pc=%h fl=%b fv=%b expected 0/180/1/1", halted, pc, flush_idex, fetch_valid); end
    $display("halt: pc=%h h=%b", pc, halted);
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    compared++; if (pc !== 32'hFFFF_FFFC || pc_4 !== 32'h0) begin mismatched++; $display("FAIL wrap_pre: pc=%h pc_4=%h expected fffffffc/0", pc, pc_4); end
    tick();
    compared++; if (pc !== 32'h0 || pc_4 !== 32'h4 || fetch_valid !== 1'b1) begin mismatched++; $display("FAIL wrap: pc=%h pc_4=%h fv=%b expected 0/4/1", pc, pc_4, fetch_valid); end
    $display("wrap: pc=%h", pc);
  endtask

  task automatic test_async_reset();
    jump = 1'b1; jump_target = 32'h80;
    tick();
    jump = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    compared++; if (halted !== 1'b1 || pc !== 32'h80) begin mismatched++; $display("FAIL pre_reset_halt: h=%b pc=%h expected 1/80", halted, pc); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (pc !== 32'h0 || halted !== 1'b0 || misalign !== 1'b0 || fetch_valid !== 1'b0) begin mismatched++; $display("FAIL async_reset: pc=%h h=%b mis=%b fv=%b expected 0/0/0/0", pc, halted, misalign, fetch_valid); end
    jump = 1'b1; jump_target = 32'h200;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    jump = 1'b0;
    compared++; if (pc !== 32'h0 || fetch_valid !== 1'b1 || flush_ifid !== 1'b0) begin mismatched++; $display("FAIL boot_ignores: pc=%h fv=%b fl=%b expected 0/1/0", pc, fetch_valid, flush_ifid); end
    tick();
    compared++; if (pc !== 32'h4) begin mismatched++; $display("FAIL post_boot: pc=%h expected 4", pc); end
    $display("async reset: pc=%h", pc);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_exception();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 5-stage MIPS pipeline. Owns the architectural PC register and selects the next fetch address each cycle: reset vector, sequential PC+4, branch target, jump target or exception vector.
- Arbitrates stall, redirect, exception and halt requests from the hazard unit, the EX stage and the control unit.
- Generates the fetch-valid and pipeline-flush pulses. Sits between the instruction memory address port and the IF/ID register.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; first fetch address.
- EXC_VECTOR, 32'h0000_0180, PC loaded on exception or misaligned redirect.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and suppress new fetch this cycle.
- br_taken  in  1  EX stage: conditional branch resolved taken.
- br_target  in  32  branch target address.
- jump  in  1  EX stage: unconditional jump.
- jump_target  in  32  jump target address.
- exc_req  in  1  exception request from any stage.
- halt_req  in  1  halt request (BREAK decoded).
- resume  in  1  leave HALT.
- pc  out  32  current fetch address.
- pc_4  out  32  pc + 4, registered alongside pc.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush_ifid  out  1  one-cycle pulse: squash IF/ID.
- flush_idex  out  1  one-cycle pulse: squash ID/EX.
- misalign  out  1  sticky: a redirect target had addr[1:0] != 0.
- halted  out  1  FSM in HALT.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, pc_4=RESET_VECTOR+4, fetch_valid=0, flushes=0, misalign=0, halted=0, state=BOOT.
- States: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after rst_n rises, then RUN with fetch_valid=1 at RESET_VECTOR. Requests sampled in BOOT are ignored.
  - RUN: each edge applies the first matching rule, highest priority first:
    - exc_req: pc<=EXC_VECTOR; flush_ifid=1; flush_idex=1.
    - br_taken or jump: pc<=target (jump overrides br_taken if both are set); flush_ifid=1; flush_idex=1. If target[1:0]!=0: pc<=EXC_VECTOR and misalign<=1 instead.
    - halt_req: pc held; fetch_valid<=0; go to HALT.
    - stall: pc and pc_4 held; fetch_valid<=0; no flush.
    - else: pc<=pc_4; pc_4<=pc_4+4; fetch_valid<=1.
  - HALT: pc held, fetch_valid=0, halted=1. exc_req exits to RUN at EXC_VECTOR with flushes. resume (without exc_req) returns to RUN next edge with fetch_valid=1 at the held pc. Other inputs are ignored.
- Redirect overrides stall: the older instruction in EX wins, and the stalled younger instruction is squashed by the flush.
- Flush pulses last exactly one cycle. Back-to-back redirects give back-to-back pulses.
- On any redirect, pc_4 <= new pc + 4.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Modulo 2^32, no flag.
- misalign clears only on reset.
- Reset mid-operation (any state) returns to BOOT immediately and asynchronously. Pending requests are dropped.

Test Plan:
- Reset release, no requests -> BOOT 1 cycle (fetch_valid=0, pc=0); then pc=0,4,8,12 on successive cycles with fetch_valid=1.
- At pc=0x10, stall high 2 cycles -> pc stays 0x10, fetch_valid=0 both cycles, no flush; next cycle pc=0x14.
- At pc=0x20: br_taken=1, br_target=0x100, stall=1 in the same cycle -> next pc=0x100, flush_ifid=flush_idex=1 for exactly one cycle, then pc=0x104. Separately, jump=1 (jump_target=0x200) with br_taken=1 -> pc=0x200.
- jump=1, jump_target=0x202 -> pc=0x180, misalign=1 and stays 1 across later normal fetches until rst_n=0.
- exc_req=1 together with br_taken=1 -> pc=0x180, flushes pulse. halt_req at pc=0x40 -> halted=1, pc frozen 0x40, fetch_valid=0; resume -> fetch_valid=1 at pc=0x40, then 0x44.
- pc=0xFFFF_FFFC, normal fetch -> pc=0x0000_0000. Assert rst_n=0 mid-HALT -> pc=0, halted=0 immediately, without waiting for a clock edge.
